// File: rtl/risc_toy_pkg.sv
// rtl/risc_toy_pkg.sv - shared RISC-TOY types and constants for the MEM stage
package risc_toy_pkg;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_BUSY = 1'b1
  } mem_state_t;

  localparam logic [1:0] RESULT_SRC_ALU = 2'b00;
  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
  localparam logic [1:0] RESULT_SRC_PC4 = 2'b10;

  localparam int REG_IDX_W = 5;

endpackage

// File: rtl/stage_mem_dmem_if_fsm.sv
// rtl/stage_mem_dmem_if_fsm.sv - data-memory request FSM, stall and load-data capture
module dmem_if_fsm
  import risc_toy_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        dmem_ready_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic        stall_o,
  output logic [31:0] read_data_o
);

  mem_state_t  state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  always_comb begin
    stall_o = (state_q == MEM_BUSY) && !dmem_ready_i;
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (state_q == MEM_BUSY && dmem_ready_i && !we_q) begin
      rdata_d = dmem_rdata_i;
    end
    // Request outputs reload on the same edge the EX/MEM register captures.
    if (!stall_o) begin
      state_d = issue_i ? MEM_BUSY : MEM_IDLE;
      we_d    = issue_i & we_i;
      addr_d  = issue_i ? addr_i : 32'h0;
      wdata_d = issue_i ? wdata_i : 32'h0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MEM_IDLE;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign dmem_req_o   = (state_q == MEM_BUSY);
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign read_data_o  = rdata_q;

endmodule

// File: rtl/stage_mem.sv
// rtl/stage_mem.sv - RISC-TOY MEM stage: EX/MEM register plus data-memory handshake (option: MEM_ALIGN_CHECK_EN)
module stage_mem
  import risc_toy_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 Valid_EX,
  input  logic [31:0]          ALU_result_EX,
  input  logic [31:0]          RD2_EX_a,
  input  logic [31:0]          PC_EX,
  input  logic                 MemRead_EX,
  input  logic                 MemWrite_EX,
  input  logic                 RegWrite_EX,
  input  logic [1:0]           ResultSrc_EX,
  input  logic [REG_IDX_W-1:0] rd_EX,
  output logic                 DMEM_REQ,
  output logic                 DMEM_WE,
  output logic [31:0]          DMEM_ADDR,
  output logic [31:0]          DMEM_WDATA,
  input  logic [31:0]          DMEM_RDATA,
  input  logic                 DMEM_READY,
  output logic                 Stall_MEM,
  output logic                 Valid_MEM,
  output logic                 RegWrite_MEM,
  output logic [1:0]           ResultSrc_MEM,
  output logic [REG_IDX_W-1:0] rd_MEM,
  output logic [31:0]          PC_MEM,
  output logic [31:0]          ALU_result_MEM,
`ifdef MEM_ALIGN_CHECK_EN
  output logic                 MisAlign_MEM,
`endif
  output logic [31:0]          ReadData_MEM
);

  logic                 valid_q, valid_d;
  logic                 reg_write_q, reg_write_d;
  logic [1:0]           result_src_q, result_src_d;
  logic [REG_IDX_W-1:0] rd_q, rd_d;
  logic [31:0]          pc_q, pc_d;
  logic [31:0]          alu_result_q, alu_result_d;
  logic                 mis_align_q, mis_align_d;
  logic                 mem_op;
  logic                 mis_align_ex;
  logic                 issue;
  logic                 stall;

  always_comb begin
    mem_op = Valid_EX & (MemRead_EX | MemWrite_EX);
`ifdef MEM_ALIGN_CHECK_EN
    mis_align_ex = mem_op & (ALU_result_EX[1:0] != 2'b00);
`else
    mis_align_ex = 1'b0;
`endif
    issue = mem_op & ~mis_align_ex;

    valid_d      = valid_q;
    reg_write_d  = reg_write_q;
    result_src_d = result_src_q;
    rd_d         = rd_q;
    pc_d         = pc_q;
    alu_result_d = alu_result_q;
    mis_align_d  = mis_align_q;
    // Held while stalled so the forwarding path sees a stable producer.
    if (!stall) begin
      valid_d      = Valid_EX;
      reg_write_d  = Valid_EX & RegWrite_EX & ~mis_align_ex;
      result_src_d = ResultSrc_EX;
      rd_d         = rd_EX;
      pc_d         = PC_EX;
      alu_result_d = ALU_result_EX;
      mis_align_d  = mis_align_ex;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      result_src_q <= RESULT_SRC_ALU;
      rd_q         <= '0;
      pc_q         <= RESET_PC;
      alu_result_q <= 32'h0;
      mis_align_q  <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      result_src_q <= result_src_d;
      rd_q         <= rd_d;
      pc_q         <= pc_d;
      alu_result_q <= alu_result_d;
      mis_align_q  <= mis_align_d;
    end
  end

  dmem_if_fsm u_dmem_if_fsm (
    .clk          (CLK),
    .rst_n        (RSTn),
    .issue_i      (issue),
    .we_i         (MemWrite_EX),
    .addr_i       (ALU_result_EX),
    .wdata_i      (RD2_EX_a),
    .dmem_ready_i (DMEM_READY),
    .dmem_rdata_i (DMEM_RDATA),
    .dmem_req_o   (DMEM_REQ),
    .dmem_we_o    (DMEM_WE),
    .dmem_addr_o  (DMEM_ADDR),
    .dmem_wdata_o (DMEM_WDATA),
    .stall_o      (stall),
    .read_data_o  (ReadData_MEM)
  );

  assign Stall_MEM      = stall;
  assign Valid_MEM      = valid_q;
  assign RegWrite_MEM   = reg_write_q;
  assign ResultSrc_MEM  = result_src_q;
  assign rd_MEM         = rd_q;
  assign PC_MEM         = pc_q;
  assign ALU_result_MEM = alu_result_q;
`ifdef MEM_ALIGN_CHECK_EN
  assign MisAlign_MEM   = mis_align_q;
`else
  logic unused_mis_align;
  assign unused_mis_align = mis_align_q;
`endif

endmodule
